// File: rtl/fir_frame_sequencer.sv
// fir_frame_sequencer
// Control sequencer for the serial FIR datapath. It checks receive framing,
// fires the FIR once for each accepted word, waits out the FIR latency, loads
// the serializer and counts the transmit bits. It also reports dropped words
// and malformed frames.
module fir_frame_sequencer #(
  parameter int DATA_WIDTH  = 24,
  parameter int FIR_LATENCY = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_rx_end,
  output logic                 o_des_valid,
  output logic                 o_fir_en,
  output logic                 o_fir_valid,
  output logic                 o_ser_load,
  output logic                 o_tx_end,
  output logic                 o_busy,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic [CNT_WIDTH-1:0] ov_drop_cnt
);

  localparam int BIT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam int LAT_W = (FIR_LATENCY > 1) ? $clog2(FIR_LATENCY) : 1;

  localparam logic [BIT_W-1:0]     LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]     BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0]     BIT_ONE  = BIT_W'(1);
  localparam logic [LAT_W-1:0]     LAT_INIT = LAT_W'(FIR_LATENCY - 1);
  localparam logic [LAT_W-1:0]     LAT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0]     LAT_ONE  = LAT_W'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_LOAD = 2'd2,
    ST_TX   = 2'd3
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [BIT_W-1:0]     rx_cnt;
  logic [BIT_W-1:0]     rx_cnt_nxt;
  logic [BIT_W-1:0]     tx_cnt;
  logic [BIT_W-1:0]     tx_cnt_nxt;
  logic [LAT_W-1:0]     lat_cnt;
  logic [LAT_W-1:0]     lat_cnt_nxt;
  logic                 word_ok;
  logic                 frame_err_nxt;
  logic                 start_word;
  logic                 load_nxt;
  logic                 tx_end_nxt;
  logic                 drop;
  logic                 overrun_nxt;
  logic [CNT_WIDTH-1:0] drop_cnt_nxt;

  // Receive framing: count bit strobes and compare against the word-end marker.
  always_comb begin
    rx_cnt_nxt    = rx_cnt;
    word_ok       = 1'b0;
    frame_err_nxt = 1'b0;
    if (i_en) begin
      if (i_rx_end) begin
        rx_cnt_nxt = BIT_ZERO;
        if (rx_cnt == LAST_BIT) begin
          word_ok = 1'b1;
        end else begin
          frame_err_nxt = 1'b1;
        end
      end else if (rx_cnt == LAST_BIT) begin
        // A full word of bits arrived without the marker, so wrap and flag it.
        rx_cnt_nxt    = BIT_ZERO;
        frame_err_nxt = 1'b1;
      end else begin
        rx_cnt_nxt = rx_cnt + BIT_ONE;
      end
    end else begin
      rx_cnt_nxt = rx_cnt;
    end
  end

  // Pipeline FSM: next state, counters and pulse requests.
  always_comb begin
    state_nxt   = state;
    tx_cnt_nxt  = tx_cnt;
    lat_cnt_nxt = lat_cnt;
    start_word  = 1'b0;
    load_nxt    = 1'b0;
    tx_end_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (word_ok) begin
          start_word  = 1'b1;
          lat_cnt_nxt = LAT_INIT;
          state_nxt   = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (lat_cnt == LAT_ZERO) begin
          load_nxt  = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          lat_cnt_nxt = lat_cnt - LAT_ONE;
        end
      end
      ST_LOAD: begin
        tx_cnt_nxt = BIT_ZERO;
        state_nxt  = ST_TX;
      end
      ST_TX: begin
        if (i_en) begin
          if (tx_cnt == LAST_BIT) begin
            tx_end_nxt = 1'b1;
            tx_cnt_nxt = BIT_ZERO;
            // A word finishing on the final TX strobe goes straight back in.
            if (word_ok) begin
              start_word  = 1'b1;
              lat_cnt_nxt = LAT_INIT;
              state_nxt   = ST_WAIT;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            tx_cnt_nxt = tx_cnt + BIT_ONE;
          end
        end else begin
          tx_cnt_nxt = tx_cnt;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Overrun tracking: any good word the pipeline cannot take is dropped.
  always_comb begin
    drop         = word_ok & ~start_word;
    overrun_nxt  = o_overrun;
    drop_cnt_nxt = ov_drop_cnt;
    if (drop) begin
      overrun_nxt = 1'b1;
      if (ov_drop_cnt != CNT_MAX) begin
        drop_cnt_nxt = ov_drop_cnt + CNT_ONE;
      end else begin
        drop_cnt_nxt = ov_drop_cnt;
      end
    end else begin
      overrun_nxt = o_overrun;
    end
  end

  // State, counters and registered outputs with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state       <= ST_IDLE;
      rx_cnt      <= BIT_ZERO;
      tx_cnt      <= BIT_ZERO;
      lat_cnt     <= LAT_ZERO;
      o_des_valid <= 1'b0;
      o_fir_en    <= 1'b0;
      o_fir_valid <= 1'b0;
      o_ser_load  <= 1'b0;
      o_tx_end    <= 1'b0;
      o_busy      <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
      ov_drop_cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      state       <= state_nxt;
      rx_cnt      <= rx_cnt_nxt;
      tx_cnt      <= tx_cnt_nxt;
      lat_cnt     <= lat_cnt_nxt;
      o_des_valid <= start_word;
      o_fir_en    <= start_word;
      o_fir_valid <= load_nxt;
      o_ser_load  <= load_nxt;
      o_tx_end    <= tx_end_nxt;
      o_busy      <= (state_nxt != ST_IDLE);
      o_frame_err <= frame_err_nxt;
      o_overrun   <= overrun_nxt;
      ov_drop_cnt <= drop_cnt_nxt;
    end
  end

endmodule

// File: doc/fir_frame_sequencer.md
Name: fir_frame_sequencer

Overview:
- Sequences the serial FIR datapath (deserializer -> fir_filter -> serializer) one sample word at a time.
- Checks receive framing by counting bit strobes against the word-end marker.
- Fires the FIR for one cycle, waits out its fixed latency, then loads the serializer and counts the transmit bits.
- Flags dropped words (overrun) and malformed frames (framing error). Sits between the serial pins and the three datapath blocks in top_level.

Parameters:
- DATA_WIDTH, 24, bits per sample word; >= 2.
- FIR_LATENCY, 4, clock cycles from o_fir_en pulse to valid FIR output; >= 1.
- CNT_WIDTH, 8, width of the dropped-word counter.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- i_en  in  1  bit strobe, one cycle per serial bit (shared RX/TX bit rate).
- i_rx_end  in  1  word-end marker; valid only when i_en=1; marks the last RX bit of a word.
- o_des_valid  out  1  one-cycle pulse: deserializer word is complete and accepted.
- o_fir_en  out  1  one-cycle FIR advance pulse; coincident with o_des_valid.
- o_fir_valid  out  1  one-cycle pulse: FIR output is valid; coincident with o_ser_load.
- o_ser_load  out  1  one-cycle pulse: serializer parallel load.
- o_tx_end  out  1  one-cycle pulse after the last TX bit strobe.
- o_busy  out  1  high whenever FSM != IDLE.
- o_frame_err  out  1  one-cycle pulse on a framing violation.
- o_overrun  out  1  sticky; set on any dropped word; cleared only by reset.
- ov_drop_cnt  out  CNT_WIDTH  count of dropped words; saturates at all-ones.

Behaviour:
- Reset (i_rst_n=0 at clock edge):
  - all outputs 0; rx_cnt=0, tx_cnt=0, lat_cnt=0, state=IDLE.
  - applies mid-operation: any in-flight word is discarded; no o_tx_end is emitted for it.
- All outputs are registered. No combinational path from inputs to outputs.
- RX framing (runs in every state), evaluated when i_en=1:
  - i_rx_end=1 and rx_cnt==DATA_WIDTH-1: word_ok; rx_cnt<=0.
  - i_rx_end=1 and rx_cnt!=DATA_WIDTH-1: o_frame_err pulse next cycle; word discarded; rx_cnt<=0.
  - i_rx_end=0 and rx_cnt==DATA_WIDTH-1: o_frame_err pulse next cycle; rx_cnt<=0 (wrap).
  - otherwise: rx_cnt<=rx_cnt+1.
  - i_rx_end with i_en=0 is ignored.
- Acceptance of word_ok:
  - Accepted if state==IDLE, or state==TX and this cycle's i_en is the DATA_WIDTH-th TX strobe (back-to-back case).
  - Otherwise the word is dropped: o_overrun<=1, and ov_drop_cnt increments (saturating). Pipeline state is unaffected.
- FSM states: IDLE, WAIT, LOAD, TX.
  - IDLE: accepted word_ok at cycle T -> T+1: o_des_valid=1, o_fir_en=1, state=WAIT, lat_cnt=FIR_LATENCY-1.
  - WAIT: if lat_cnt==0 -> LOAD, else lat_cnt-1. With FIR_LATENCY=1, WAIT lasts one cycle.
  - LOAD: o_ser_load=1 and o_fir_valid=1 for exactly this cycle; tx_cnt<=0; -> TX.
    - o_ser_load is at T+1+FIR_LATENCY.
  - TX: each i_en increments tx_cnt. On the strobe where tx_cnt==DATA_WIDTH-1:
    - o_tx_end pulses the next cycle;
    - state -> IDLE, or -> WAIT with o_des_valid/o_fir_en pulses if a word is accepted in the same cycle.
- o_frame_err and word_ok never coincide for the same strobe.
- o_fir_en never asserts outside an accepted word.
- o_ser_load is never issued while TX is in progress.

Test Plan:
- Reset, DATA_WIDTH=24, FIR_LATENCY=4: send 24 strobes with i_rx_end on the 24th at cycle T -> o_des_valid/o_fir_en high at T+1, o_ser_load/o_fir_valid at T+5; after 24 more strobes, o_tx_end pulses once; o_busy falls the same cycle.
- i_rx_end on the 10th strobe -> o_frame_err one pulse; no o_fir_en. Then a 24-strobe word -> accepted normally.
- 30 strobes without i_rx_end -> o_frame_err after strobe 24; rx_cnt wraps. A following correct word is accepted.
- Second word completes during WAIT -> o_overrun=1, ov_drop_cnt=1, first word's o_ser_load timing unchanged. Repeat 300 times with CNT_WIDTH=8 -> ov_drop_cnt holds at 255.
- RX word end on the same strobe as the 24th TX strobe -> o_tx_end and o_fir_en both pulse next cycle; no overrun.
- Assert i_rst_n=0 for one cycle in the middle of TX -> all outputs 0 next cycle, o_overrun cleared, no o_tx_end. Next word processes normally.
